// File: rtl/spi_slave_pkg.sv
// Shared types for the parametrised SPI slave: FSM states, command codes,
// and the width helper used to size the payload.
package spi_slave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHK_CMD,
    ST_WRITE,
    ST_READ_ADD,
    ST_READ_DATA,
    ST_TX_WAIT,
    ST_TX_SHIFT
  } state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  function automatic int spi_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// MISO serialiser, MSB first. With SPI_PARITY_EN an even-parity bit
// is appended after the DATA_W data bits.
module spi_tx_shifter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_shift,
  output logic              o_bit,
  output logic              o_last
);

`ifdef SPI_PARITY_EN
  localparam int TX_W = DATA_W + 1;
`else
  localparam int TX_W = DATA_W;
`endif
  localparam int CW = $clog2(TX_W + 1);

  logic [TX_W-1:0] r_sh;
  logic [CW-1:0]   r_cnt;
  logic [TX_W-1:0] w_load_val;

`ifdef SPI_PARITY_EN
  assign w_load_val = {i_data, ^i_data};
`else
  assign w_load_val = i_data;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_sh  <= w_load_val;
      r_cnt <= '0;
    end else if (i_shift) begin
      r_sh  <= {r_sh[TX_W-2:0], 1'b0};
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_bit  = r_sh[TX_W-1];
  assign o_last = (r_cnt == CW'(TX_W - 1));

endmodule

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave front-end for the single-port RAM.
// Optional frame parity in both directions under SPI_PARITY_EN.
module spi_slave_param
  import spi_slave_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               SS_n,
  input  logic                               MOSI,
  input  logic [DATA_W-1:0]                  tx_data,
  input  logic                               tx_valid,
  output logic                               MISO,
  output logic [spi_max(ADDR_W,DATA_W)+1:0]  rx_data,
  output logic                               rx_valid,
  output logic                               frame_err
);

  localparam int PAY_W = spi_max(ADDR_W, DATA_W);
  localparam int RX_W  = PAY_W + 2;
`ifdef SPI_PARITY_EN
  localparam int FRAME_W = RX_W + 1;
`else
  localparam int FRAME_W = RX_W;
`endif
  localparam int CNT_W = $clog2(FRAME_W + 1);

  state_e r_state, w_state_n;

  logic [FRAME_W-2:0] r_frame;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_armed;

  logic [FRAME_W-1:0] w_frame;
  logic [RX_W-1:0]    w_body;
  logic [1:0]         w_cmd;
  logic               w_par_ok;
  logic               w_rx_st;
  logic               w_last;
  logic               w_ok;
  logic               w_err;
  logic               w_arm_set;
  logic               w_arm_clr;
  logic               w_load;
  logic               w_shift;
  logic               w_tx_bit;
  logic               w_tx_last;

  // Full frame as it stands once the bit on MOSI is included
  assign w_frame = {r_frame, MOSI};
  assign w_body  = w_frame[FRAME_W-1 -: RX_W];
  assign w_cmd   = w_body[RX_W-1 -: 2];
`ifdef SPI_PARITY_EN
  assign w_par_ok = ~^w_frame;
`else
  assign w_par_ok = 1'b1;
`endif

  assign w_rx_st = (r_state == ST_WRITE) ||
                   (r_state == ST_READ_ADD) ||
                   (r_state == ST_READ_DATA);
  assign w_last  = (r_cnt == CNT_W'(FRAME_W - 2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    w_ok      = 1'b0;
    w_err     = 1'b0;
    w_arm_set = 1'b0;
    w_arm_clr = 1'b0;
    w_load    = 1'b0;
    w_shift   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!SS_n) w_state_n = ST_CHK_CMD;
      end
      ST_CHK_CMD: begin
        if (SS_n)       w_state_n = ST_IDLE;
        else if (!MOSI) w_state_n = ST_WRITE;
        else if (r_armed) w_state_n = ST_READ_DATA;
        else            w_state_n = ST_READ_ADD;
      end
      ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
        if (SS_n) begin
          w_err     = 1'b1;
          w_state_n = ST_IDLE;
        end else if (w_last) begin
          w_state_n = ST_CHK_CMD;
          if (!w_par_ok) begin
            w_err = 1'b1;
          end else if (r_state == ST_WRITE) begin
            w_ok = 1'b1;
          end else if (r_state == ST_READ_ADD) begin
            if (w_cmd == CMD_RD_DATA) begin
              w_err = 1'b1;
            end else begin
              w_ok      = 1'b1;
              w_arm_set = 1'b1;
            end
          end else begin
            w_ok = 1'b1;
            if (w_cmd == CMD_RD_DATA) begin
              w_arm_clr = 1'b1;
              w_state_n = ST_TX_WAIT;
            end
          end
        end
      end
      ST_TX_WAIT: begin
        if (SS_n) begin
          w_err     = 1'b1;
          w_state_n = ST_IDLE;
        end else if (tx_valid) begin
          w_load    = 1'b1;
          w_state_n = ST_TX_SHIFT;
        end
      end
      ST_TX_SHIFT: begin
        if (SS_n) begin
          w_err     = 1'b1;
          w_state_n = ST_IDLE;
        end else begin
          w_shift = 1'b1;
          if (w_tx_last) w_state_n = ST_IDLE;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  // Bit counter restarts on every state change so it never wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame   <= '0;
      r_cnt     <= '0;
      r_armed   <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (w_state_n != r_state) r_cnt <= '0;
      else if (w_rx_st)         r_cnt <= r_cnt + CNT_W'(1);
      if (r_state == ST_CHK_CMD)
        r_frame <= {{(FRAME_W-2){1'b0}}, MOSI};
      else if (w_rx_st)
        r_frame <= w_frame[FRAME_W-2:0];
      if (w_arm_set)      r_armed <= 1'b1;
      else if (w_arm_clr) r_armed <= 1'b0;
      if (w_ok) rx_data <= w_body;
      rx_valid  <= w_ok;
      frame_err <= w_err;
    end
  end

  spi_tx_shifter #(
    .DATA_W (DATA_W)
  ) u_tx (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_data  (tx_data),
    .i_shift (w_shift),
    .o_bit   (w_tx_bit),
    .o_last  (w_tx_last)
  );

  assign MISO = (r_state == ST_TX_SHIFT) & w_tx_bit;

endmodule
